// File: rtl/drm_stream_bridge_pkg.sv
// Shared field positions, link state and TX sample layout for the DRM stream bridge.
package drm_stream_bridge_pkg;

   localparam int CS_BIT   = 5;
   localparam int CYC_BIT  = 4;
   localparam int ADR_HI   = 3;
   localparam int ADR_LO   = 2;
   localparam int WE_BIT   = 1;
   localparam int DAT_BIT  = 0;

   localparam int ACK_BIT  = 3;
   localparam int INTR_BIT = 2;
   localparam int STA_BIT  = 1;
   localparam int RDAT_BIT = 0;

   localparam int TX_USED_BITS = 6;
   localparam int RX_USED_BITS = 4;

   typedef enum logic {LINK_DOWN = 1'b0, LINK_UP = 1'b1} link_state_t;

   // Field order matches the TX word bit positions above (cs is the MSB).
   typedef struct packed {
      logic       cs;
      logic       cyc;
      logic [1:0] adr;
      logic       we;
      logic       dat;
   } tx_sample_t;

   function automatic logic [31:0] tx_word(input tx_sample_t s);
      return {{(32 - TX_USED_BITS){1'b0}}, s};
   endfunction

endpackage

// File: rtl/drm_stream_sync_fifo.sv
// Synchronous FIFO with registered head (dout valid whenever !empty) and sync flush.
// Write on full is ignored unless a read frees the slot in the same cycle.
module drm_stream_sync_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] din,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             wr_ok;
   logic             rd_ok;

   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_ok);

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         dout   <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
         // Head register: bypass the write when the queue is (or becomes) empty.
         if (wr_ok && (empty || (rd_ok && count == (AW+1)'(1)))) begin
            dout <= din;
         end else if (rd_ok) begin
            dout <= mem[rd_ptr + AW'(1)];
         end
      end
   end

endmodule

// File: rtl/drm_controller_stream_bridge.sv
// Packs DRM controller bus-master pins into TX stream words and unpacks RX words onto its inputs.
// Pin-to-tdata latency 2 cycles; TX stalls buffer in a FIFO (overflow sticky), RX is always ready.
module drm_controller_stream_bridge
   import drm_stream_bridge_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int LINK_TIMEOUT = 1024
) (
   input  logic        drm_aclk,
   input  logic        drm_arst,
   input  logic        drm_bus_master_o_cs,
   input  logic        drm_bus_master_o_cyc,
   input  logic [1:0]  drm_bus_master_o_adr,
   input  logic        drm_bus_master_o_we,
   input  logic        drm_bus_master_o_dat,
   output logic        drm_bus_master_i_ack,
   output logic        drm_bus_master_i_intr,
   output logic        drm_bus_master_i_sta,
   output logic        drm_bus_master_i_dat,
   output logic        drm_to_uip_tvalid,
   input  logic        drm_to_uip_tready,
   output logic [31:0] drm_to_uip_tdata,
   input  logic        uip_to_drm_tvalid,
   output logic        uip_to_drm_tready,
   input  logic [31:0] uip_to_drm_tdata,
   output logic        link_up,
   output logic        tx_overflow,
   output logic        rx_format_err
);

   localparam int CW = (LINK_TIMEOUT > 2) ? $clog2(LINK_TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(LINK_TIMEOUT - 1);

   tx_sample_t  sample_q;
   tx_sample_t  last_pushed;
   link_state_t state;
   link_state_t state_nxt;
   logic [CW-1:0] tmo_cnt;

   logic rx_beat;
   logic link_drop;
   logic push_req;
   logic push_ok;
   logic pop;
   logic fifo_full;
   logic fifo_empty;
   logic [TX_USED_BITS-1:0] fifo_dout;

   assign uip_to_drm_tready = ~drm_arst;
   assign rx_beat           = uip_to_drm_tvalid && uip_to_drm_tready;
   assign link_up           = (state == LINK_UP);

   always_comb begin
      state_nxt = state;
      case (state)
         LINK_DOWN: if (rx_beat) state_nxt = LINK_UP;
         LINK_UP:   if (!rx_beat && tmo_cnt == CNT_MAX) state_nxt = LINK_DOWN;
         default:   state_nxt = LINK_DOWN;
      endcase
   end

   assign link_drop = (state == LINK_UP) && (state_nxt == LINK_DOWN);

   // cyc=1 carries serial data, so every cycle is a word even if the pins repeat.
   assign push_req = link_up && (sample_q.cyc || (sample_q != last_pushed));
   assign pop      = drm_to_uip_tvalid && drm_to_uip_tready;
   assign push_ok  = push_req && (!fifo_full || pop);

   always_ff @(posedge drm_aclk) begin
      if (drm_arst) begin
         sample_q              <= '0;
         last_pushed           <= '0;
         state                 <= LINK_DOWN;
         tmo_cnt               <= '0;
         drm_bus_master_i_ack  <= 1'b0;
         drm_bus_master_i_intr <= 1'b0;
         drm_bus_master_i_sta  <= 1'b0;
         drm_bus_master_i_dat  <= 1'b0;
         tx_overflow           <= 1'b0;
         rx_format_err         <= 1'b0;
      end else begin
         sample_q <= '{cs:  drm_bus_master_o_cs,
                       cyc: drm_bus_master_o_cyc,
                       adr: drm_bus_master_o_adr,
                       we:  drm_bus_master_o_we,
                       dat: drm_bus_master_o_dat};
         state <= state_nxt;

         if (rx_beat || state == LINK_DOWN) begin
            tmo_cnt <= '0;
         end else if (tmo_cnt != CNT_MAX) begin
            tmo_cnt <= tmo_cnt + CW'(1);
         end

         if (link_drop) begin
            last_pushed <= '0;
         end else if (push_ok) begin
            last_pushed <= sample_q;
         end

         if (push_req && fifo_full && !pop) begin
            tx_overflow <= 1'b1;
         end

         if (link_drop) begin
            drm_bus_master_i_ack  <= 1'b0;
            drm_bus_master_i_intr <= 1'b0;
            drm_bus_master_i_sta  <= 1'b0;
            drm_bus_master_i_dat  <= 1'b0;
         end else if (rx_beat) begin
            drm_bus_master_i_ack  <= uip_to_drm_tdata[ACK_BIT];
            drm_bus_master_i_intr <= uip_to_drm_tdata[INTR_BIT];
            drm_bus_master_i_sta  <= uip_to_drm_tdata[STA_BIT];
            drm_bus_master_i_dat  <= uip_to_drm_tdata[RDAT_BIT];
         end

         if (rx_beat && (|uip_to_drm_tdata[31:RX_USED_BITS])) begin
            rx_format_err <= 1'b1;
         end
      end
   end

   drm_stream_sync_fifo #(
      .WIDTH (TX_USED_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_tx_fifo (
      .clk   (drm_aclk),
      .rst   (drm_arst),
      .flush (link_drop),
      .wr_en (push_ok),
      .din   (sample_q),
      .rd_en (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign drm_to_uip_tvalid = !fifo_empty;
   assign drm_to_uip_tdata  = tx_word(tx_sample_t'(fifo_dout));

endmodule
